// File: rtl/jtframe_joyser_ctrl.sv
// ---------------------------------------------------------------------------
// jtframe_joyser_ctrl
//
// Scanner for the two-player serial joystick chain, which is a 74HC165-style
// parallel-load shift register. The block drives JOY_LOAD low to capture the
// buttons. It then clocks 24 bits out over JOY_CLK and publishes two
// active-high 12-bit joystick words together with a one-cycle frame strobe.
// All timing uses clock enables derived from clk_sys. No derived clocks are
// generated.
//
// Parameters
//   DIV    clk_sys cycles per JOY_CLK half-period (2..4096)
//   NBITS  serial bits per frame; must be 24
//
// Ports
//   clk_sys    in   system clock
//   rst        in   asynchronous, active-high reset
//   en         in   scan enable (level, sampled only between frames)
//   joy_data   in   serial data from the chain, active-low buttons
//   joy_clk    out  shift clock to the chain (registered)
//   joy_load   out  parallel load to the chain, active-low (registered)
//   joy1       out  player 1 buttons, active-high
//   joy2       out  player 2 buttons, active-high
//   scan_done  out  one-cycle pulse in the cycle joy1/joy2 update
//   busy       out  high while a frame is in progress
//
// Optional build macro
//   JTFRAME_JOYSER_DEBOUNCE_EN  an output bit changes only when two
//                               consecutive frames agree on it
// ---------------------------------------------------------------------------
module jtframe_joyser_ctrl #(
   parameter int DIV   = 128,
   parameter int NBITS = 24
)(
   input  logic        clk_sys,
   input  logic        rst,
   input  logic        en,
   input  logic        joy_data,
   output logic        joy_clk,
   output logic        joy_load,
   output logic [11:0] joy1,
   output logic [11:0] joy2,
   output logic        scan_done,
   output logic        busy
);

   if (NBITS != 24) begin : g_bad_nbits
      $error("jtframe_joyser_ctrl: NBITS must be 24");
   end
   if (DIV < 2 || DIV > 4096) begin : g_bad_div
      $error("jtframe_joyser_ctrl: DIV must be in 2..4096");
   end

   localparam int            DW       = $clog2(DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      LATCH
   } state_t;

   state_t           state;
   logic [DW-1:0]    div_cnt;
   logic [4:0]       bit_cnt;
   logic [1:0]       data_sync;
   logic [NBITS-1:0] shreg;       // wire levels, bit 0 = first serial bit
   logic             div_wrap;
   logic             frame_end;
   logic [23:0]      pressed;     // active-high view of the raw sample
   logic [23:0]      cur_map;     // {joy2, joy1} built from this frame
   logic [23:0]      next_map;    // value loaded into {joy2, joy1} at LATCH

   // Serial index to output bit. The result is packed as {joy2, joy1}.
   function automatic logic [23:0] map_bits(input logic [23:0] p);
      logic [11:0] j1;
      logic [11:0] j2;
      j1[8]  = p[0];   j1[6]  = p[1];   j1[5]  = p[2];   j1[4]  = p[3];
      j1[0]  = p[4];   j1[1]  = p[5];   j1[2]  = p[6];   j1[3]  = p[7];
      j2[8]  = p[8];   j2[6]  = p[9];   j2[5]  = p[10];  j2[4]  = p[11];
      j2[0]  = p[12];  j2[1]  = p[13];  j2[2]  = p[14];  j2[3]  = p[15];
      j2[10] = p[16];  j2[11] = p[17];  j2[9]  = p[18];  j2[7]  = p[19];
      j1[10] = p[20];  j1[11] = p[21];  j1[9]  = p[22];  j1[7]  = p[23];
      return {j2, j1};
   endfunction

   assign div_wrap  = (div_cnt == DIV_LAST);
   // This is the falling toggle that ends serial period 23.
   assign frame_end = (state == SHIFT) && div_wrap && joy_clk && (bit_cnt == 5'd23);
   // The wire is active-low. Inverting it here gives pressed = 1.
   assign pressed   = ~shreg;
   assign cur_map   = map_bits(pressed);

`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
   logic [23:0] prev_raw;         // previous frame's active-high sample
   logic [23:0] prev_map;
   logic [23:0] agree;

   assign prev_map = map_bits(prev_raw);
   assign agree    = ~(cur_map ^ prev_map);
   // Bits on which the two frames disagree keep their published value.
   assign next_map = (cur_map & agree) | ({joy2, joy1} & ~agree);

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst)            prev_raw <= '0;
      else if (frame_end) prev_raw <= pressed;
   end
`else
   assign next_map = cur_map;
`endif

   // The chain output is asynchronous to clk_sys. A 2-flop synchroniser
   // resolves metastability. Its reset value is the released level.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) data_sync <= 2'b11;
      // NOTE: sequential state always uses <= so every flop samples pre-edge values.
      else     data_sync <= {data_sync[0], joy_data};
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         shreg     <= '1;
         joy_clk   <= 1'b0;
         joy_load  <= 1'b1;
         joy1      <= '0;
         joy2      <= '0;
         scan_done <= 1'b0;
         busy      <= 1'b0;
      end else begin
         scan_done <= 1'b0;
         case (state)
            IDLE: begin
               div_cnt <= '0;
               bit_cnt <= '0;
               joy_clk <= 1'b0;
               if (en) begin
                  state    <= LOAD;
                  joy_load <= 1'b0;
                  busy     <= 1'b1;
               end
            end

            // joy_load stays low for one full joy_clk period: DIV cycles low
            // and DIV cycles high. The rising edge here shifts nothing
            // because the chain is still loading.
            LOAD: begin
               div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
               if (div_wrap) begin
                  joy_clk <= ~joy_clk;
                  if (joy_clk) begin
                     state    <= SHIFT;
                     joy_load <= 1'b1;
                     bit_cnt  <= '0;
                  end
               end
            end

            // Sample in the cycle that drives joy_clk 0->1. The synchronised
            // value is two cycles old, so it still shows the chain output
            // from before this rising edge.
            SHIFT: begin
               div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
               if (div_wrap) begin
                  joy_clk <= ~joy_clk;
                  if (!joy_clk) begin
                     shreg <= {data_sync[1], shreg[NBITS-1:1]};
                  end else if (bit_cnt == 5'd23) begin
                     state        <= LATCH;
                     {joy2, joy1} <= next_map;
                     scan_done    <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
            end

            // The divider is held at 0 so that a back-to-back LOAD starts
            // with a fresh half-period.
            LATCH: begin
               div_cnt <= '0;
               bit_cnt <= '0;
               joy_clk <= 1'b0;
               if (en) begin
                  state    <= LOAD;
                  joy_load <= 1'b0;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtframe_joyser_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for jtframe_joyser_ctrl with DIV=4. A frame therefore lasts
// 50*4+1 = 201 cycles. A behavioural 74HC165 chain feeds the DUT from a
// 24-bit wire pattern (1 = released).
// ---------------------------------------------------------------------------
module tb_jtframe_joyser_ctrl;

   localparam int DIV = 4;
   localparam int FRAME = 50 * DIV + 1;

   logic        clk_sys = 1'b0;
   logic        rst;
   logic        en;
   logic        joy_data;
   logic        joy_clk;
   logic        joy_load;
   logic [11:0] joy1;
   logic [11:0] joy2;
   logic        scan_done;
   logic        busy;

   int errors = 0;
   int checks = 0;

   logic [23:0] pat = '1;   // wire level per serial index
   logic [5:0]  idx;

   always #5 clk_sys = ~clk_sys;

   jtframe_joyser_ctrl #(.DIV(DIV), .NBITS(24)) dut (
      .clk_sys   (clk_sys),
      .rst       (rst),
      .en        (en),
      .joy_data  (joy_data),
      .joy_clk   (joy_clk),
      .joy_load  (joy_load),
      .joy1      (joy1),
      .joy2      (joy2),
      .scan_done (scan_done),
      .busy      (busy)
   );

   // Chain model. While loading, the first bit is on the output. Each rising
   // joy_clk with load released moves on to the next bit. 1s shift in behind.
   always @(posedge joy_clk or negedge joy_load) begin
      if (!joy_load) idx <= '0;
      else if (idx < 6'd24) idx <= idx + 6'd1;
   end
   assign joy_data = (idx < 6'd24) ? pat[idx[4:0]] : 1'b1;

   task automatic wait_scan(input int max_cycles, output bit got);
      int n = 0;
      got = 1'b0;
      while (!got && n < max_cycles) begin
         @(negedge clk_sys);
         n++;
         if (scan_done) got = 1'b1;
      end
   endtask

   task automatic wait_idle(input int max_cycles, output bit got);
      int n = 0;
      got = 1'b0;
      while (!got && n < max_cycles) begin
         @(negedge clk_sys);
         n++;
         if (!busy) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b0;
      repeat (3) @(negedge clk_sys);
      checks++; if (joy_clk !== 1'b0)   begin errors++; $display("FAIL reset_joy_clk got=%b exp=0", joy_clk); end
      checks++; if (joy_load !== 1'b1)  begin errors++; $display("FAIL reset_joy_load got=%b exp=1", joy_load); end
      checks++; if (joy1 !== 12'h000)   begin errors++; $display("FAIL reset_joy1 got=%h exp=000", joy1); end
      checks++; if (joy2 !== 12'h000)   begin errors++; $display("FAIL reset_joy2 got=%h exp=000", joy2); end
      checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL reset_scan_done got=%b exp=0", scan_done); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b0;
      repeat (5) @(negedge clk_sys);
      checks++; if (busy !== 1'b0 || joy_load !== 1'b1 || joy_clk !== 1'b0) begin
         errors++; $display("FAIL idle_no_en busy=%b load=%b clk=%b exp=0/1/0", busy, joy_load, joy_clk);
      end
   endtask

   // All buttons released, en held high: frame timing and back-to-back frames.
   task automatic test_back_to_back();
      int load_low = 0;
      int nscan = 0;
      int scan_t[3];
      bit busy_ok = 1'b1;
      bit got;
      pat = '1;
      en  = 1'b1;
      for (int t = 0; t < 3 * FRAME + 5; t++) begin
         @(negedge clk_sys);
         if (t == 0) begin
            checks++; if (joy_load !== 1'b0 || busy !== 1'b1) begin
               errors++; $display("FAIL load_entry load=%b busy=%b exp=0/1", joy_load, busy);
            end
         end
         if (t < FRAME && !joy_load) load_low++;
         if (t < FRAME && !busy) busy_ok = 1'b0;
         if (scan_done) begin
            if (nscan < 3) scan_t[nscan] = t;
            nscan++;
         end
      end
      checks++; if (load_low != 2 * DIV) begin errors++; $display("FAIL load_low_cycles got=%0d exp=%0d", load_low, 2 * DIV); end
      checks++; if (!busy_ok) begin errors++; $display("FAIL busy_in_frame got=0 exp=1"); end
      checks++; if (nscan != 3) begin errors++; $display("FAIL scan_count got=%0d exp=3", nscan); end
      else begin
         checks++; if (scan_t[0] != FRAME - 1)     begin errors++; $display("FAIL scan1_time got=%0d exp=%0d", scan_t[0], FRAME - 1); end
         checks++; if (scan_t[1] != 2 * FRAME - 1) begin errors++; $display("FAIL scan2_time got=%0d exp=%0d", scan_t[1], 2 * FRAME - 1); end
         checks++; if (scan_t[2] != 3 * FRAME - 1) begin errors++; $display("FAIL scan3_time got=%0d exp=%0d", scan_t[2], 3 * FRAME - 1); end
      end
      checks++; if (joy1 !== 12'h000 || joy2 !== 12'h000) begin
         errors++; $display("FAIL released_words joy1=%h joy2=%h exp=000/000", joy1, joy2);
      end
      en = 1'b0;
      wait_idle(2 * FRAME, got);
      checks++; if (!got) begin errors++; $display("FAIL b2b_idle_timeout busy=%b exp=0", busy); end
   endtask

   // Buttons at serial indices 0 (start) and 22 (coin).
   task automatic test_map_start_coin();
      bit got;
      pat = ~24'h400001;
      en  = 1'b1;
      wait_scan(2 * FRAME, got);
      checks++; if (!got) begin errors++; $display("FAIL map_a_timeout scan_done=0 exp=1"); end
      checks++; if (joy1 !== 12'h300) begin errors++; $display("FAIL map_a_joy1 got=%h exp=300", joy1); end
      checks++; if (joy2 !== 12'h000) begin errors++; $display("FAIL map_a_joy2 got=%h exp=000", joy2); end
      en = 1'b0;
      wait_idle(2 * FRAME, got);
      checks++; if (!got) begin errors++; $display("FAIL map_a_idle_timeout busy=%b exp=0", busy); end
   endtask

   // en is high for one cycle, which starts exactly one frame. The chain
   // has buttons at indices 4, 7, 12 and 18.
   task automatic test_single_frame();
      int busy_cnt = 0;
      int nscan = 0;
      pat = ~24'h041090;
      en  = 1'b1;
      for (int i = 0; i < FRAME + 60; i++) begin
         @(negedge clk_sys);
         if (busy) busy_cnt++;
         if (scan_done) nscan++;
         if (i == 0) en = 1'b0;
      end
      checks++; if (busy_cnt != FRAME) begin errors++; $display("FAIL single_busy_cycles got=%0d exp=%0d", busy_cnt, FRAME); end
      checks++; if (nscan != 1) begin errors++; $display("FAIL single_scan_count got=%0d exp=1", nscan); end
      checks++; if (joy_clk !== 1'b0 || joy_load !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL single_idle clk=%b load=%b busy=%b exp=0/1/0", joy_clk, joy_load, busy);
      end
      checks++; if (joy1 !== 12'h009) begin errors++; $display("FAIL map_b_joy1 got=%h exp=009", joy1); end
      checks++; if (joy2 !== 12'h201) begin errors++; $display("FAIL map_b_joy2 got=%h exp=201", joy2); end
   endtask

   // Reset arrives around SHIFT bit 10. The first frame after release must
   // publish the new buttons (indices 1, 2, 17) and nothing stale.
   task automatic test_reset_mid_frame();
      bit got = 1'b0;
      bit early = 1'b0;
      int n = 0;
      pat = ~24'h020006;
      en  = 1'b1;
      repeat (2 * DIV + 20 * DIV + 2) @(negedge clk_sys);
      checks++; if (busy !== 1'b1 || joy_load !== 1'b1) begin
         errors++; $display("FAIL midframe_state busy=%b load=%b exp=1/1", busy, joy_load);
      end
      rst = 1'b1;
      #1;
      checks++; if (joy1 !== 12'h000 || joy2 !== 12'h000) begin
         errors++; $display("FAIL rst_async_words joy1=%h joy2=%h exp=000/000", joy1, joy2);
      end
      checks++; if (busy !== 1'b0 || joy_load !== 1'b1 || joy_clk !== 1'b0 || scan_done !== 1'b0) begin
         errors++; $display("FAIL rst_async_ctrl busy=%b load=%b clk=%b done=%b exp=0/1/0/0", busy, joy_load, joy_clk, scan_done);
      end
      repeat (2) @(negedge clk_sys);
      rst = 1'b0;
      while (!got && n < 2 * FRAME) begin
         @(negedge clk_sys);
         n++;
         if (scan_done) got = 1'b1;
         else if (joy1 !== 12'h000 || joy2 !== 12'h000) early = 1'b1;
      end
      checks++; if (!got) begin errors++; $display("FAIL post_rst_timeout scan_done=0 exp=1"); end
      checks++; if (early) begin errors++; $display("FAIL partial_update got=1 exp=0"); end
      checks++; if (joy1 !== 12'h060) begin errors++; $display("FAIL post_rst_joy1 got=%h exp=060", joy1); end
      checks++; if (joy2 !== 12'h800) begin errors++; $display("FAIL post_rst_joy2 got=%h exp=800", joy2); end
      en = 1'b0;
      wait_idle(2 * FRAME, got);
      checks++; if (!got) begin errors++; $display("FAIL post_rst_idle_timeout busy=%b exp=0", busy); end
   endtask

   // Index 3 (joy1[4]) over back-to-back frames: pressed, released,
   // pressed, released, pressed, pressed.
   task automatic test_button_sequence();
      logic [23:0] seq [6] = '{24'h8, 24'h0, 24'h8, 24'h0, 24'h8, 24'h8};
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
      logic        exp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
      logic        exp [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
      bit got;
      // A fresh reset clears any history left by the earlier frames.
      rst = 1'b1;
      @(negedge clk_sys);
      rst = 1'b0;
      @(negedge clk_sys);
      pat = ~seq[0];
      en  = 1'b1;
      for (int f = 0; f < 6; f++) begin
         wait_scan(2 * FRAME, got);
         checks++; if (!got) begin errors++; $display("FAIL seq_timeout frame=%0d scan_done=0 exp=1", f); end
         checks++; if (joy1[4] !== exp[f]) begin
            errors++; $display("FAIL seq_joy1_4 frame=%0d got=%b exp=%b", f, joy1[4], exp[f]);
         end
         if (f < 5) pat = ~seq[f + 1];
      end
      en = 1'b0;
      wait_idle(2 * FRAME, got);
      checks++; if (!got) begin errors++; $display("FAIL seq_idle_timeout busy=%b exp=0", busy); end
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      test_reset();
      test_back_to_back();
      test_map_start_coin();
      test_single_frame();
      test_reset_mid_frame();
      test_button_sequence();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jtframe_joyser_ctrl.md
Name: jtframe_joyser_ctrl

Overview:
- Synchronous scanner for the two-player serial joystick chain: a 74HC165-style parallel-load shift register read over JOY_CLK, JOY_LOAD and JOY_DATA.
- Sequences load and shift, samples 24 bits per frame and publishes two active-high 12-bit joystick words plus a frame strobe.
- Runs on clk_sys with clock-enable timing only. It generates no derived clocks.
- Sits between the board pins and the core's joystick1/joystick2 inputs.

Parameters:
- DIV, 128: clk_sys cycles per JOY_CLK half-period. Legal range 2..4096.
- NBITS, 24: serial bits per frame. Fixed at 24 for the mapping below; any other value is a synthesis error.

Ports:
- clk_sys  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  scan enable (level)
- joy_data  in  1  serial data from chain, active-low buttons
- joy_clk  out  1  shift clock to chain (registered)
- joy_load  out  1  parallel load, active-low (registered)
- joy1  out  12  player 1 buttons, active-high
- joy2  out  12  player 2 buttons, active-high
- scan_done  out  1  one-cycle pulse when joy1/joy2 update
- busy  out  1  high while a frame is in progress

Behaviour:
- Reset (async, rst=1): state IDLE, divider 0, bit counter 0, joy_clk=0, joy_load=1, joy1=joy2=0, scan_done=0, busy=0, shift registers all 1 (released). Reset asserted mid-frame aborts immediately. Outputs keep reset values until the first complete frame after release.
- Input sync: joy_data passes through a 2-flop synchroniser (reset value 1). All sampling uses the synchronised value.
- Divider: counts 0..DIV-1 while not IDLE. At DIV-1 it wraps and joy_clk toggles. joy_clk is forced 0 in IDLE.
- IDLE: busy=0. If en=1, go to LOAD on the next cycle. The divider restarts at 0.
- LOAD: joy_load=0 for exactly 2*DIV cycles, i.e. one full joy_clk period (DIV low, DIV high). Then joy_load=1 and go to SHIFT with the bit counter at 0.
- SHIFT: 24 joy_clk periods.
  - Bit k is sampled on the clk_sys cycle in which joy_clk is driven 0->1 during period k.
  - The synchronised value is 2 cycles old, so the sample reflects the chain output before the edge.
  - The sample is stored inverted: a wire value of 0 means pressed, stored as 1.
  - After bit 23 go to LATCH.
- LATCH: one cycle. joy1/joy2 load from the shift registers, scan_done=1 for that cycle, joy_clk=0. Next state is LOAD if en=1, else IDLE.
- Frame length: 2*DIV + 48*DIV + 1 = 50*DIV+1 cycles, LOAD entry to LATCH inclusive. Back-to-back frames have no gap.
- en deasserted mid-frame: the current frame completes and publishes, then the block goes to IDLE. en toggling within a frame has no effect.
- busy=1 in LOAD, SHIFT and LATCH.
- Bit mapping, serial index to output bit:
  - 0:joy1[8] start, 1:joy1[6], 2:joy1[5], 3:joy1[4], 4:joy1[0] right, 5:joy1[1] left, 6:joy1[2] down, 7:joy1[3] up
  - 8:joy2[8], 9:joy2[6], 10:joy2[5], 11:joy2[4], 12:joy2[0], 13:joy2[1], 14:joy2[2], 15:joy2[3]
  - 16:joy2[10], 17:joy2[11], 18:joy2[9] coin, 19:joy2[7]
  - 20:joy1[10], 21:joy1[11], 22:joy1[9] coin, 23:joy1[7]
- joy1/joy2 change only in the LATCH cycle. No partial-frame values are ever visible.

Optional Feature:
- Macro: JTFRAME_JOYSER_DEBOUNCE_EN.
- When defined: the block keeps the previous frame's raw sample. In LATCH each output bit updates only if the current and previous raw samples agree. Otherwise the output bit holds its value. scan_done still pulses every frame. The previous-sample register resets to 0.
- When undefined: outputs take the raw sample every LATCH, as described above.

Test Plan:
- DIV=4, en=1, chain model returns all 1s: LOAD entered the cycle after en. joy_load low for 8 cycles. scan_done first at cycle 201 after LOAD entry, then every 201 cycles. joy1=joy2=12'h000.
- DIV=4, chain drives 0 at serial index 0 and 22 only: after first scan_done, joy1=12'h300 (bits 8,9), joy2=12'h000.
- DIV=4, chain drives 0 at indices 4,7,12,18: joy1=12'h009, joy2=12'h201.
- en pulsed 1 for one cycle, then 0: exactly one frame runs (201 cycles, busy high throughout). One scan_done, then IDLE with joy_clk=0 and joy_load=1.
- rst asserted at SHIFT bit 10 with buttons pressed: all outputs return to reset values immediately. The next frame after release publishes correct values and no stale bits.
- With JTFRAME_JOYSER_DEBOUNCE_EN: button toggles on every frame, so joy1[4] never changes. Button held for 2 frames: joy1[4]=1 after the 2nd scan_done, not the 1st.
